sdram_arbit_mc: RTL and testbench

- Parametrised multi-channel command arbiter for the SDRAM controller.
- Multiplexes init, auto-refresh and CHANNELS client command sources (read/write engines, DMA ports) onto one SDRAM cmd/ba/addr bus.
- Auto-refresh has strict priority at grant boundaries. Clients are served round-robin.
- A per-grant watchdog releases hung clients and reports them.

---
 rtl/sdram_arbit_mc_if.sv | 48 ++++
 rtl/sdram_arbit_mc.sv | 173 +++++++++++++++++
 tb/tb_sdram_arbit_mc.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_mc_if.sv
// Command-bus bundle between the SDRAM command sources and the arbiter.
// The arbiter side uses the master modport and the source/SDRAM side uses the slave modport.
interface sdram_arbit_mc_if #(
   parameter int CHANNELS = 2,
   parameter int ADDR_W   = 13,
   parameter int BA_W     = 2
);
   logic [3:0]               init_cmd;
   logic [BA_W-1:0]          init_ba;
   logic [ADDR_W-1:0]        init_addr;
   logic                     init_end;

   logic                     aref_req;
   logic                     aref_en;
   logic [3:0]               aref_cmd;
   logic [BA_W-1:0]          aref_ba;
   logic [ADDR_W-1:0]        aref_addr;
   logic                     aref_end;

   logic [CHANNELS-1:0]      ch_req;
   logic [CHANNELS-1:0]      ch_en;
   logic [4*CHANNELS-1:0]    ch_cmd;
   logic [BA_W*CHANNELS-1:0] ch_ba;
   logic [ADDR_W*CHANNELS-1:0] ch_addr;
   logic [CHANNELS-1:0]      ch_end;

   logic [3:0]               out_cmd;
   logic [BA_W-1:0]          out_ba;
   logic [ADDR_W-1:0]        out_addr;
   logic                     init_done;
   logic                     err_timeout;

   modport master (
      input  init_cmd, init_ba, init_addr, init_end,
      input  aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
      input  ch_req, ch_cmd, ch_ba, ch_addr, ch_end,
      output aref_en, ch_en,
      output out_cmd, out_ba, out_addr, init_done, err_timeout
   );

   modport slave (
      output init_cmd, init_ba, init_addr, init_end,
      output aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
      output ch_req, ch_cmd, ch_ba, ch_addr, ch_end,
      input  aref_en, ch_en,
      input  out_cmd, out_ba, out_addr, init_done, err_timeout
   );
endinterface

// File: rtl/sdram_arbit_mc.sv
// SDRAM command arbiter: init, auto-refresh and round-robin clients share one cmd/ba/addr bus.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_INIT | power-up sequence owns the bus, waiting for init_end
//   ST_ARB  | one-cycle-minimum NOP gap, requests sampled here only
//   ST_AREF | auto-refresh owns the bus until aref_end
//   ST_CH   | client sel owns the bus until ch_end[sel] or watchdog expiry
module sdram_arbit_mc #(
   parameter int         CHANNELS = 2,
   parameter int         ADDR_W   = 13,
   parameter int         BA_W     = 2,
   parameter logic [3:0] CMD_NOP  = 4'b0111,
   parameter int         TIMEOUT  = 1024
) (
   input logic clk,
   input logic rst_n,
   sdram_arbit_mc_if.master bus
);

   localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_ARB  = 2'd1,
      ST_AREF = 2'd2,
      ST_CH   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] rr_q, rr_d;
   logic [PW-1:0] sel_q, sel_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          err_q, err_d;
   logic          done_q, done_d;

   logic          found;
   logic [PW-1:0] pick_idx;
   logic          sel_end;
   logic [PW-1:0] rr_next;

   // Round-robin pick: the requester at the smallest distance from rr_ptr wins.
   always_comb begin
      int best;
      best     = CHANNELS;
      pick_idx = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         int off;
         off = k - int'(rr_q);
         if (off < 0) off = off + CHANNELS;
         if (bus.ch_req[k] && (off < best)) begin
            best     = off;
            pick_idx = PW'(k);
         end
      end
      found = (best < CHANNELS);
   end

   // Done pulse of the granted channel only; other channels' pulses are ignored.
   always_comb begin
      sel_end = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel_q == PW'(k)) sel_end = bus.ch_end[k];
      end
   end

   assign rr_next = (sel_q == PW'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;

   // Next-state and register updates for the grant sequencer.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      sel_d   = sel_q;
      wd_d    = wd_q;
      err_d   = 1'b0;
      done_d  = done_q;
      case (state_q)
         ST_INIT: begin
            if (bus.init_end) begin
               state_d = ST_ARB;
               done_d  = 1'b1;
            end
         end
         ST_ARB: begin
            if (bus.aref_req) begin
               state_d = ST_AREF;
            end else if (found) begin
               sel_d   = pick_idx;
               state_d = ST_CH;
            end
         end
         ST_AREF: begin
            if (bus.aref_end) state_d = ST_ARB;
         end
         ST_CH: begin
            wd_d = wd_q + 1'b1;
            if (sel_end) begin
               state_d = ST_ARB;
               rr_d    = rr_next;
               wd_d    = '0;
            end else if ((TIMEOUT != 0) && (wd_q == WW'(TIMEOUT - 1))) begin
               state_d = ST_ARB;
               rr_d    = rr_next;
               wd_d    = '0;
               err_d   = 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Sequencer registers; reset returns to INIT and forgets the round-robin position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         rr_q    <= '0;
         sel_q   <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   // Grants decode straight from registered state so they drop with reset.
   always_comb begin
      bus.ch_en = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         bus.ch_en[k] = (state_q == ST_CH) && (sel_q == PW'(k));
      end
   end

   assign bus.aref_en     = (state_q == ST_AREF);
   assign bus.err_timeout = err_q;
   assign bus.init_done   = done_q;

   // Bus mux: the owner's fields, or a NOP with all-ones bank/address in the gap.
   always_comb begin
      bus.out_cmd  = CMD_NOP;
      bus.out_ba   = '1;
      bus.out_addr = '1;
      case (state_q)
         ST_INIT: begin
            bus.out_cmd  = bus.init_cmd;
            bus.out_ba   = bus.init_ba;
            bus.out_addr = bus.init_addr;
         end
         ST_AREF: begin
            bus.out_cmd  = bus.aref_cmd;
            bus.out_ba   = bus.aref_ba;
            bus.out_addr = bus.aref_addr;
         end
         ST_CH: begin
            for (int k = 0; k < CHANNELS; k++) begin
               if (sel_q == PW'(k)) begin
                  bus.out_cmd  = bus.ch_cmd[4*k +: 4];
                  bus.out_ba   = bus.ch_ba[BA_W*k +: BA_W];
                  bus.out_addr = bus.ch_addr[ADDR_W*k +: ADDR_W];
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_arbit_mc.sv
// Bench for sdram_arbit_mc with three clients and a 16-cycle watchdog.
// Expected grants come from a transaction-level model: who wins, for how long, and where the pointer goes.
module tb_sdram_arbit_mc;

   localparam int N    = 3;
   localparam int AW   = 13;
   localparam int BW   = 2;
   localparam int TOUT = 16;

   logic clk;
   logic rst_n;

   sdram_arbit_mc_if #(.CHANNELS(N), .ADDR_W(AW), .BA_W(BW)) bus ();

   sdram_arbit_mc #(
      .CHANNELS (N),
      .ADDR_W   (AW),
      .BA_W     (BW),
      .CMD_NOP  (4'b0111),
      .TIMEOUT  (TOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ptr    = 0;

   logic [4*N-1:0]  cmd_v;
   logic [BW*N-1:0] ba_v;
   logic [AW*N-1:0] addr_v;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tk();
      @(posedge clk);
      #2;
   endtask

   function automatic int pick(input logic [N-1:0] req, input int p);
      for (int i = 0; i < N; i++) begin
         int c;
         c = (p + i) % N;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic new_fields();
      logic [63:0] r;
      r = {$urandom, $urandom};
      cmd_v  = r[4*N-1:0];
      ba_v   = $urandom;
      r = {$urandom, $urandom};
      addr_v = r[AW*N-1:0];
      bus.ch_cmd    = cmd_v;
      bus.ch_ba     = ba_v;
      bus.ch_addr   = addr_v;
      bus.aref_cmd  = 4'($urandom);
      bus.aref_ba   = 2'($urandom);
      bus.aref_addr = 13'($urandom);
   endtask

   task automatic chk_gap(input string tag);
      check(tag, 32'(bus.ch_en), 32'd0);
      check(tag, 32'(bus.aref_en), 32'd0);
      check(tag, 32'(bus.out_cmd), 32'h7);
      check(tag, 32'(bus.out_ba), 32'h3);
      check(tag, 32'(bus.out_addr), 32'h1fff);
   endtask

   task automatic chk_grant(input string tag, input int c);
      check(tag, 32'(bus.ch_en), 32'(1 << c));
      check(tag, 32'(bus.aref_en), 32'd0);
      check(tag, 32'(bus.out_cmd), 32'(cmd_v[4*c +: 4]));
      check(tag, 32'(bus.out_ba), 32'(ba_v[BW*c +: BW]));
      check(tag, 32'(bus.out_addr), 32'(addr_v[AW*c +: AW]));
   endtask

   task automatic chk_aref(input string tag);
      check(tag, 32'(bus.aref_en), 32'd1);
      check(tag, 32'(bus.ch_en), 32'd0);
      check(tag, 32'(bus.out_cmd), 32'(bus.aref_cmd));
      check(tag, 32'(bus.out_addr), 32'(bus.aref_addr));
   endtask

   // In CH cycle 0 of channel c: hold the grant for len cycles, stray pulses on other channels, then end it.
   task automatic grant_body(input int c, input int len, input logic aref_mid);
      logic [N-1:0] others;
      for (int i = 0; i < len - 1; i++) begin
         others = N'($urandom) & ~N'(1 << c);
         bus.ch_end = others;
         if (aref_mid && i == 0) bus.aref_req = 1'b1;
         tk();
         check("hold_ch_en", 32'(bus.ch_en), 32'(1 << c));
         check("hold_no_err", 32'(bus.err_timeout), 32'd0);
         check("hold_aref_wait", 32'(bus.aref_en), 32'd0);
      end
      bus.ch_end = N'(1 << c) | (N'($urandom) & ~N'(1 << c));
      tk();
      bus.ch_end = '0;
      chk_gap("end_gap");
      check("end_no_err", 32'(bus.err_timeout), 32'd0);
      ptr = (c + 1) % N;
   endtask

   // Starts in an ARB cycle: present requests, expect refresh first, then the round-robin winner.
   task automatic arb_round(input logic [N-1:0] req, input logic aref, input int len, input int alen);
      int c;
      bus.ch_req   = req;
      bus.aref_req = aref;
      if (aref) begin
         for (int i = 0; i < alen; i++) begin
            tk();
            bus.aref_req = 1'b0;
            chk_aref("aref_grant");
         end
         bus.aref_end = 1'b1;
         tk();
         bus.aref_end = 1'b0;
         chk_gap("aref_gap");
      end
      c = pick(req, ptr);
      tk();
      if (c < 0) begin
         chk_gap("idle");
      end else begin
         chk_grant("grant", c);
         grant_body(c, len, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      int c;
      rst_n         = 1'b0;
      bus.init_cmd  = 4'b0010;
      bus.init_ba   = 2'b01;
      bus.init_addr = 13'h0400;
      bus.init_end  = 1'b0;
      bus.aref_req  = 1'b0;
      bus.aref_end  = 1'b0;
      bus.ch_req    = '0;
      bus.ch_end    = '0;
      new_fields();
      #3;
      check("rst_ch_en", 32'(bus.ch_en), 32'd0);
      check("rst_aref_en", 32'(bus.aref_en), 32'd0);
      check("rst_err", 32'(bus.err_timeout), 32'd0);
      check("rst_init_done", 32'(bus.init_done), 32'd0);
      check("rst_out_cmd", 32'(bus.out_cmd), 32'h2);
      tk();
      rst_n = 1'b1;

      // Init owns the bus until init_end is seen at a rising edge.
      for (int i = 1; i < 10; i++) begin
         tk();
         check("init_out_cmd", 32'(bus.out_cmd), 32'h2);
         check("init_out_addr", 32'(bus.out_addr), 32'h0400);
         check("init_not_done", 32'(bus.init_done), 32'd0);
      end
      bus.init_end = 1'b1;
      #1;
      check("init_last_cmd", 32'(bus.out_cmd), 32'h2);
      tk();
      chk_gap("first_arb");
      check("init_done", 32'(bus.init_done), 32'd1);
      ptr = 0;

      // Round robin with all clients requesting: 0,1,2,0.
      for (int g = 0; g < 4; g++) begin
         c = pick(3'b111, ptr);
         check("rr_model_order", 32'(c), 32'(g % N));
         arb_round(3'b111, 1'b0, 4, 1);
      end

      // Refresh wins over a simultaneous client request, client follows after one gap.
      new_fields();
      arb_round(3'b010, 1'b1, 3, 2);

      // End on the same cycle the watchdog would fire: normal end.
      new_fields();
      arb_round(3'b001, 1'b0, TOUT, 1);

      // Watchdog: channel 0 never ends, channel 1 waiting.
      new_fields();
      bus.ch_req = 3'b001;
      tk();
      chk_grant("to_grant", 0);
      bus.ch_req = 3'b011;
      for (int i = 1; i < TOUT; i++) begin
         tk();
         check("to_hold", 32'(bus.ch_en), 32'd1);
         check("to_no_err", 32'(bus.err_timeout), 32'd0);
      end
      tk();
      chk_gap("to_release");
      check("to_err_pulse", 32'(bus.err_timeout), 32'd1);
      ptr = 1;
      c = pick(3'b011, ptr);
      tk();
      check("to_err_one_cycle", 32'(bus.err_timeout), 32'd0);
      chk_grant("to_next", c);
      grant_body(c, 3, 1'b0);

      // Refresh raised mid-grant waits for the grant to end plus one gap.
      new_fields();
      bus.ch_req = 3'b100;
      c = pick(3'b100, ptr);
      tk();
      chk_grant("mid_aref_grant", c);
      grant_body(c, 4, 1'b1);
      bus.ch_req = '0;
      tk();
      chk_aref("mid_aref_follow");
      bus.aref_req = 1'b0;
      bus.aref_end = 1'b1;
      tk();
      bus.aref_end = 1'b0;
      chk_gap("mid_aref_gap");

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         new_fields();
         arb_round(N'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                   $urandom_range(1, 12), $urandom_range(1, 4));
      end

      // Reset mid-grant with rr_ptr away from zero.
      new_fields();
      arb_round(3'b010, 1'b0, 2, 1);
      bus.ch_req = 3'b100;
      tk();
      chk_grant("pre_rst_grant", 2);
      tk();
      rst_n = 1'b0;
      bus.init_end = 1'b0;
      bus.ch_req = 3'b111;
      #1;
      check("rst_mid_ch_en", 32'(bus.ch_en), 32'd0);
      check("rst_mid_aref_en", 32'(bus.aref_en), 32'd0);
      check("rst_mid_out_cmd", 32'(bus.out_cmd), 32'h2);
      check("rst_mid_done", 32'(bus.init_done), 32'd0);
      tk();
      tk();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tk();
         check("post_rst_no_grant", 32'(bus.ch_en), 32'd0);
         check("post_rst_init_cmd", 32'(bus.out_cmd), 32'h2);
      end
      bus.init_end = 1'b1;
      tk();
      chk_gap("post_rst_arb");
      ptr = 0;
      arb_round(3'b111, 1'b0, 2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
